// File: rtl/gcd_lcm_pkg.sv
// Shared definitions for the GCD/LCM coprocessor unit and the decoder that launches it.
package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GCD,
    DIV,
    MUL,
    DONE
  } gcd_state_t;

  localparam logic OP_GCD = 1'b0;
  localparam logic OP_LCM = 1'b1;

  localparam logic [6:0] OPC_GCD = 7'b0000000;
  localparam logic [6:0] OPC_LCM = 7'b0000001;

endpackage

// File: rtl/gcd_lcm_divmul.sv
// Iterative WIDTH-cycle divider / multiplier sharing one {hi,lo} shift register
// and one adder/subtractor. A divide is started with go & !mul. Asserting
// go & mul while the divide finishes chains a multiply onto the fresh quotient,
// which stays in lo and becomes the multiplier, with no idle cycle in between.
module gcd_lcm_divmul
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic                 mul,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 fin,
  output logic [2*WIDTH-1:0]   acc_next
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic             mode_mul;
  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] add_x;
  logic [WIDTH+1:0] add_y;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  // One restoring-divide or shift-add step through the shared adder/subtractor.
  always_comb begin
    add_x = mode_mul ? {2'b00, hi} : {1'b0, hi, lo[WIDTH-1]};
    add_y = mode_mul ? {2'b00, opnd} : ~{2'b00, opnd};
    sum   = add_x + add_y + {{(WIDTH+1){1'b0}}, ~mode_mul};
    if (mode_mul) begin
      if (lo[0]) begin
        {hi_step, lo_step} = {sum[WIDTH:0], lo[WIDTH-1:1]};
      end else begin
        {hi_step, lo_step} = {1'b0, hi, lo[WIDTH-1:1]};
      end
    end else if (!sum[WIDTH+1]) begin
      {hi_step, lo_step} = {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
    end else begin
      {hi_step, lo_step} = {hi[WIDTH-2:0], lo, 1'b0};
    end
    fin      = active && (cnt == LAST);
    acc_next = {hi_step, lo_step};
  end

  // Operand load, divide-to-multiply chaining and per-cycle stepping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      mode_mul <= 1'b0;
      active   <= 1'b0;
      cnt      <= '0;
    end else if (go && !mul) begin
      hi       <= '0;
      lo       <= x;
      opnd     <= y;
      mode_mul <= 1'b0;
      active   <= 1'b1;
      cnt      <= '0;
    end else if (go && mul) begin
      hi       <= '0;
      lo       <= active ? lo_step : lo;
      opnd     <= y;
      mode_mul <= 1'b1;
      active   <= 1'b1;
      cnt      <= '0;
    end else if (active) begin
      hi  <= hi_step;
      lo  <= lo_step;
      cnt <= cnt + CW'(1);
      if (fin) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD/LCM execution unit: Stein GCD here, then for lcm a divide
// a/g and multiply (a/g)*b in the shared divmul datapath. busy stalls the pipe.
module gcd_lcm_unit
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int KW = $clog2(WIDTH);

  gcd_state_t state;
  gcd_state_t state_next;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               op_r;
  logic [WIDTH-1:0]   u;
  logic [WIDTH-1:0]   v;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   g;
  logic               match;
  logic               go;
  logic               mul;
  logic [WIDTH-1:0]   dm_y;
  logic               fin;
  logic [2*WIDTH-1:0] acc_next;
  logic               load_zero;
  logic               load_gcd;
  logic               load_prod;

  gcd_lcm_divmul #(
    .WIDTH(WIDTH)
  ) u_divmul (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (go),
    .mul      (mul),
    .x        (a_r),
    .y        (dm_y),
    .fin      (fin),
    .acc_next (acc_next)
  );

  // Next-state decode plus divmul handshake and result-load strobes.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    mul        = 1'b0;
    dm_y       = b_r;
    load_zero  = 1'b0;
    load_gcd   = 1'b0;
    load_prod  = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    g          = u << k;
    match      = u[0] && v[0] && (u == v);
    unique case (state)
      IDLE: begin
        if (start) begin
          if (a == '0 || b == '0) begin
            state_next = DONE;
            load_zero  = 1'b1;
          end else begin
            state_next = GCD;
          end
        end
      end
      GCD: begin
        if (match) begin
          if (op_r == OP_LCM) begin
            state_next = DIV;
            go         = 1'b1;
            dm_y       = g;
          end else begin
            state_next = DONE;
            load_gcd   = 1'b1;
          end
        end
      end
      DIV: begin
        if (fin) begin
          state_next = MUL;
          go         = 1'b1;
          mul        = 1'b1;
        end
      end
      MUL: begin
        if (fin) begin
          state_next = DONE;
          load_prod  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset drops any operation in flight back to IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch at launch and one binary-GCD reduction step per GCD cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_r  <= '0;
      b_r  <= '0;
      op_r <= OP_GCD;
      u    <= '0;
      v    <= '0;
      k    <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        a_r  <= a;
        b_r  <= b;
        op_r <= op;
        u    <= a;
        v    <= b;
        k    <= '0;
      end
    end else if (state == GCD) begin
      if (!u[0] && !v[0]) begin
        u <= u >> 1;
        v <= v >> 1;
        k <= k + KW'(1);
      end else if (!u[0]) begin
        u <= u >> 1;
      end else if (!v[0]) begin
        v <= v >> 1;
      end else if (u > v) begin
        u <= (u - v) >> 1;
      end else if (v > u) begin
        v <= (v - u) >> 1;
      end
    end
  end

  // Result and overflow flag, written only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= '0;
      ovf    <= 1'b0;
    end else if (load_zero) begin
      result <= (op == OP_LCM) ? '0 : (a | b);
      ovf    <= 1'b0;
    end else if (load_gcd) begin
      result <= g;
      ovf    <= 1'b0;
    end else if (load_prod) begin
      result <= acc_next[WIDTH-1:0];
      ovf    <= |acc_next[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: directed vector table, protocol
// sequences (start while busy, reset during MUL) and random pairs vs a model.
module tb_gcd_lcm_unit;
  import gcd_lcm_pkg::*;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 300;
  localparam int NV      = 15;
  localparam int NRAND   = 300;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  int          tests = 0;
  int          failures = 0;
  int          done_count = 0;
  int          lat;
  logic [31:0] got_res;
  logic        got_ovf;
  logic        timed_out;
  vec_t        vecs [NV];

  gcd_lcm_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  function automatic int stein_steps(input logic [31:0] a_i, input logic [31:0] b_i);
    logic [31:0] u;
    logic [31:0] v;
    int n;
    u = a_i;
    v = b_i;
    n = 0;
    while (n < 1000) begin
      n++;
      if (!u[0] && !v[0]) begin
        u = u >> 1;
        v = v >> 1;
      end else if (!u[0]) u = u >> 1;
      else if (!v[0]) v = v >> 1;
      else if (u == v) break;
      else if (u > v) u = (u - v) >> 1;
      else v = (v - u) >> 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_gcd(input logic [31:0] a_i, input logic [31:0] b_i);
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] t;
    x = a_i;
    y = b_i;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [63:0] ref_lcm(input logic [31:0] a_i, input logic [31:0] b_i);
    logic [31:0] g;
    if (a_i == 0 || b_i == 0) return 64'd0;
    g = ref_gcd(a_i, b_i);
    return 64'(a_i / g) * 64'(b_i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitDone(output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic applyStimulus(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    @(negedge clk);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(negedge clk);
    start = 1'b0;
    op    = ~op_i;
    a     = $urandom;
    b     = $urandom;
    waitDone(lat);
    timed_out = (done !== 1'b1);
    got_res   = result;
    got_ovf   = ovf;
    if (timed_out) begin
      tests++;
      failures++;
      $display("[TB] FAIL timeout op=%0d a=0x%0h b=0x%0h: no done after %0d cycles", op_i, a_i, b_i, lat);
    end
  endtask

  task automatic runVector(input string name, input logic op_i, input logic [31:0] a_i,
                           input logic [31:0] b_i, input logic [31:0] exp_res, input logic exp_ovf);
    int exp_lat;
    exp_lat = (a_i == 0 || b_i == 0) ? 1 :
              1 + stein_steps(a_i, b_i) + ((op_i == OP_LCM) ? 2 * WIDTH : 0);
    applyStimulus(op_i, a_i, b_i);
    if (!timed_out) begin
      checkOutput($sformatf("%s result", name), 64'(got_res), 64'(exp_res));
      checkOutput($sformatf("%s ovf", name), 64'(got_ovf), 64'(exp_ovf));
      checkOutput($sformatf("%s latency", name), 64'(lat), 64'(exp_lat));
    end
  endtask

  initial begin
    int dc0;
    int cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rop;
    logic [63:0] l;

    vecs[0]  = '{OP_GCD, 32'd48,         32'd18,         32'd6,          1'b0};
    vecs[1]  = '{OP_LCM, 32'd4,          32'd6,          32'd12,         1'b0};
    vecs[2]  = '{OP_GCD, 32'd0,          32'd7,          32'd7,          1'b0};
    vecs[3]  = '{OP_GCD, 32'd9,          32'd0,          32'd9,          1'b0};
    vecs[4]  = '{OP_GCD, 32'd0,          32'd0,          32'd0,          1'b0};
    vecs[5]  = '{OP_LCM, 32'd0,          32'd7,          32'd0,          1'b0};
    vecs[6]  = '{OP_LCM, 32'd7,          32'd0,          32'd0,          1'b0};
    vecs[7]  = '{OP_LCM, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0002,  1'b1};
    vecs[8]  = '{OP_GCD, 32'd64,         32'd192,        32'd64,         1'b0};
    vecs[9]  = '{OP_LCM, 32'd8,          32'd16,         32'd16,         1'b0};
    vecs[10] = '{OP_LCM, 32'h8000_0000,  32'd3,          32'h8000_0000,  1'b1};
    vecs[11] = '{OP_GCD, 32'd12,         32'd12,         32'd12,         1'b0};
    vecs[12] = '{OP_LCM, 32'h0001_0000,  32'h0003_0000,  32'h0003_0000,  1'b0};
    vecs[13] = '{OP_GCD, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0};
    vecs[14] = '{OP_LCM, 32'd3,          32'd5,          32'd15,         1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset ovf", 64'(ovf), 64'd0);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf);
    end

    // Latency bounds on gcd(48,18) and the gcd(1, 2^32-1) worst case
    runVector("gcd48_18", OP_GCD, 32'd48, 32'd18, 32'd6, 1'b0);
    checkOutput("gcd48_18 latency bound", 64'(lat <= 2 * WIDTH + 2), 64'd1);
    runVector("gcd1_max", OP_GCD, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    checkOutput("gcd1_max within 65", 64'(lat <= 65), 64'd1);

    // Zero operand: busy during DONE, idle one cycle later
    runVector("zero gcd", OP_GCD, 32'd0, 32'd5, 32'd5, 1'b0);
    checkOutput("busy during done", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("done after pulse", 64'(done), 64'd0);
    checkOutput("busy after done", 64'(busy), 64'd0);

    // Start held high and re-pulsed while busy
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1;
    op    = OP_LCM;
    a     = 32'd4;
    b     = 32'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = OP_GCD;
      a  = $urandom;
      b  = $urandom;
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc);
    if (done !== 1'b1) begin
      tests++;
      failures++;
      $display("[TB] FAIL busy-start timeout: no done after %0d cycles", cyc);
    end else begin
      checkOutput("busy-start result", 64'(result), 64'd12);
      checkOutput("busy-start ovf", 64'(ovf), 64'd0);
    end
    repeat (5) @(negedge clk);
    checkOutput("busy-start done count", 64'(done_count - dc0), 64'd1);
    checkOutput("busy-start idle", 64'(busy), 64'd0);

    // Reset during MUL aborts: no done, result cleared
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1;
    op    = OP_LCM;
    a     = 32'd3;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort result", 64'(result), 64'd0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort no done", 64'(done_count - dc0), 64'd0);
    runVector("after abort lcm3_5", OP_LCM, 32'd3, 32'd5, 32'd15, 1'b0);

    // Random pairs against the model, with a bias toward power-of-two results
    for (int i = 0; i < NRAND; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1: begin
          ra = 32'($urandom_range(0, 1000));
          rb = 32'($urandom_range(0, 1000));
        end
        2: begin
          ra = 32'd1 << $urandom_range(0, 31);
          rb = 32'($urandom_range(1, 15)) << $urandom_range(0, 20);
        end
        default: begin
          cyc = int'($urandom_range(1, 5000));
          ra  = 32'(cyc) * 32'($urandom_range(0, 3000));
          rb  = 32'(cyc) * 32'($urandom_range(1, 3000));
        end
      endcase
      rop = 1'($urandom_range(0, 1));
      if (rop == OP_LCM) begin
        l = ref_lcm(ra, rb);
        runVector($sformatf("rand%0d lcm(0x%0h,0x%0h)", i, ra, rb), rop, ra, rb, l[31:0], |l[63:32]);
      end else begin
        runVector($sformatf("rand%0d gcd(0x%0h,0x%0h)", i, ra, rb), rop, ra, rb, ref_gcd(ra, rb), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
